// File: rtl/carrega_matriz.sv
// Host-side matrix RAM loader/unloader: streams 2*N_ELEM operands into RAM
// starting at address 0, and streams N_ELEM results back out from RES_BASE.
module carrega_matriz #(
  parameter int DATA_W   = 9,
  parameter int N_ELEM   = 25,
  parameter int ADDR_W   = 8,
  parameter int RES_BASE = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              load_done,
  input  logic              read_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              read_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(2*N_ELEM);
  localparam logic [CNT_W-1:0]  LAST_LD = CNT_W'(2*N_ELEM-1);
  localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(N_ELEM-1);
  localparam logic [ADDR_W-1:0] RES_A   = ADDR_W'(RES_BASE);

  if ((RES_BASE + N_ELEM - 1 >= 2**ADDR_W) || (2*N_ELEM > 2**ADDR_W)) begin : g_bad_map
    $error("carrega_matriz: matrix map does not fit in ADDR_W address bits");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_END, LOAD_DONE, RD_ISSUE, RD_WAIT, RD_OUT, RD_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (load_start)      state_n = LOAD;
                 else if (read_start) state_n = RD_ISSUE;
      LOAD:      if (in_valid && cnt == LAST_LD) state_n = LOAD_END;
      LOAD_END:  state_n = LOAD_DONE;
      LOAD_DONE: state_n = IDLE;
      RD_ISSUE:  state_n = RD_WAIT;
      RD_WAIT:   state_n = RD_OUT;
      RD_OUT:    if (out_ready) state_n = (cnt < LAST_RD) ? RD_ISSUE : RD_DONE;
      RD_DONE:   state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_done = 1'b0;
    read_done = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      LOAD:      in_ready  = 1'b1;
      LOAD_DONE: load_done = 1'b1;
      RD_OUT:    out_valid = 1'b1;
      RD_DONE:   read_done = 1'b1;
      default:   ;
    endcase
  end

  // RAM port and counter. The read address is set up on entry to RD_ISSUE so
  // it is already stable for the whole cycle the RAM samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      out_data  <= '0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) cnt <= '0;
          else if (read_start) begin
            cnt      <= '0;
            ram_addr <= RES_A;
          end
        end
        LOAD: begin
          if (in_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= ADDR_W'(cnt);
            ram_wdata <= in_data;
            if (cnt != LAST_LD) cnt <= cnt + 1'b1;
          end
        end
        RD_WAIT: out_data <= ram_rdata;
        RD_OUT: begin
          if (out_ready && cnt < LAST_RD) begin
            cnt      <= cnt + 1'b1;
            ram_addr <= RES_A + ADDR_W'(cnt) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/carrega_matriz.md
Name: carrega_matriz

Overview:
Host-side loader/unloader for the matrix RAM. It is the opposite end of the coprocessor's matrix manager, which reads two 5x5 operand matrices from RAM and writes the result matrix back.
- Load: accepts a serial stream of 2*N_ELEM operand elements (matrix A, then matrix B) over a valid/ready handshake and writes them to RAM addresses 0..2*N_ELEM-1.
- Unload: reads the N_ELEM result words starting at RES_BASE and streams them out over a valid/ready handshake.

Parameters:
DATA_W, 9, element width in bits
N_ELEM, 25, elements per matrix (5x5)
ADDR_W, 8, RAM address width
RES_BASE, 50, RAM address of result element 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_start  in  1  request operand load; sampled in IDLE only
in_valid  in  1  in_data valid
in_data  in  DATA_W  operand element; row-major, A[0..24] then B[0..24]
in_ready  out  1  block accepts in_data this cycle
load_done  out  1  one-cycle pulse, load complete
read_start  in  1  request result readback; sampled in IDLE only
out_valid  out  1  out_data valid
out_data  out  DATA_W  result element, row-major
out_ready  in  1  consumer accepts out_data
read_done  out  1  one-cycle pulse, readback complete
busy  out  1  high whenever state != IDLE
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_we  out  1  RAM write enable (registered)
ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after ram_addr is sampled

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state IDLE; all outputs 0; element counter 0.
- rst asserted mid-operation: immediate return to IDLE with ram_we=0. No done pulse. A partial load is abandoned, and the next load restarts at address 0.
- States: IDLE, LOAD, LOAD_END, LOAD_DONE, RD_ISSUE, RD_WAIT, RD_OUT, RD_DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - load_start moves to LOAD and clears the counter.
  - Otherwise read_start moves to RD_ISSUE and clears the counter.
  - load_start wins if both are high.
  - in_valid, out_ready and starts in any non-IDLE state are ignored.
- LOAD:
  - in_ready=1.
  - On handshake (in_valid & in_ready) at cycle k, cycle k+1 has ram_we=1, ram_addr=cnt, ram_wdata=in_data(k); cnt increments.
  - Cycles with no handshake: ram_we=0.
  - The handshake with cnt = 2*N_ELEM-1 moves to LOAD_END.
- LOAD_END: in_ready=0; the final write is presented (ram_we=1).
- LOAD_DONE: load_done=1 for exactly one cycle, then IDLE.
  - Timing: last handshake at cycle k gives last write at k+1 and load_done at k+2.
- RD_ISSUE: ram_we=0; ram_addr=RES_BASE+cnt held stable; RAM samples it at the end of this cycle.
- RD_WAIT: ram_rdata valid; captured into out_data at the end of the cycle.
- RD_OUT:
  - out_valid=1; out_data held constant until out_ready=1.
  - On out_valid & out_ready: cnt increments. Go to RD_ISSUE if cnt < N_ELEM-1, else to RD_DONE.
  - Minimum 3 cycles per element.
- RD_DONE: out_valid=0, read_done=1 for one cycle, then IDLE.
- Counter: counts 0..2*N_ELEM-1 (6 bits for the defaults). It never wraps, and is cleared on every start.
- Address arithmetic: unsigned, ADDR_W bits. RES_BASE+N_ELEM-1 must be < 2^ADDR_W (elaboration-time check).
- ram_addr and ram_wdata retain their last value while ram_we=0.
- No data transformation: elements pass through bit-exact.

Test Plan:
1. Full load: load_start, then in_valid held high with data 1..50 -> exactly 50 ram_we pulses, addresses 0..49, data 1..50. in_ready falls the cycle after the 50th handshake; load_done single pulse 2 cycles after it; busy low the following cycle.
2. Input backpressure: in_valid high on alternate cycles with data 100..149 -> exactly 50 writes, addresses 0..49 in order, no duplicates or gaps; ram_we=0 on idle cycles.
3. Readback: RAM model holds 200+i at address 50+i, out_ready=1 -> 25 beats out_data 200..224 in order, each beat >=3 cycles apart. read_done pulses once after beat 224; out_valid=0 during RD_DONE.
4. Output stall: out_ready=0 for 5 cycles while beat 3 (out_data=203) is valid -> out_valid and out_data=203 held stable. Next beat is 204; total 25 beats.
5. Reset mid-load: assert rst after 10 handshakes -> all outputs 0 asynchronously, no load_done. A new load of 7..56 writes address 0 = 7 through 49 = 56.
6. Arbitration: load_start and read_start high in the same IDLE cycle -> LOAD entered, ram_we used for writes. read_start pulsed during LOAD is ignored; no out_valid until an explicit read_start from IDLE.
